// File: rtl/config_pkg.sv
// Shared configuration for the serial interface blocks: default UART timing
// and the transmitter state encoding.
package config_pkg;

   localparam int UartClkDiv   = 174;  // 20 MHz core clock / 115200 baud
   localparam int UartStopBits = 1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } UartStateT;

endpackage

// File: rtl/uart_baud_gen.sv
// Down-counting bit-period timer: load restarts a full period, o_tick marks the
// last cycle of each period and the counter reloads itself while running.
module uart_baud_gen #(
   parameter int ClkDiv = 174
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic i_load,
   input  logic i_run,
   output logic o_tick
);

   localparam int              CntW   = $clog2(ClkDiv);
   localparam logic [CntW-1:0] Reload = CntW'(ClkDiv - 1);

   logic [CntW-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= Reload;
      end else if (i_run) begin
         r_cnt <= (r_cnt == '0) ? Reload : r_cnt - CntW'(1);
      end
   end

   assign o_tick = i_run && (r_cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter draining a byte FIFO through a data/have_next/next
// handshake; back-to-back frames are launched with no idle gap.
module uart_tx
   import config_pkg::*;
#(
   parameter int ClkDiv   = UartClkDiv,
   parameter int StopBits = UartStopBits
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       enable,
   input  logic [7:0] data,
   input  logic       have_next,
   output logic       next,
   output logic       tx,
   output logic       busy
);

   localparam logic StopCntInit = 1'(StopBits - 1);

   UartStateT  r_state;
   logic [7:0] r_shift;
   logic [2:0] r_bit_cnt;
   logic       r_stop_cnt;
   logic       r_tx;
   logic       r_next;
   logic       r_busy;

   UartStateT  w_state_nxt;
   logic [7:0] w_shift_nxt;
   logic [2:0] w_bit_cnt_nxt;
   logic       w_stop_cnt_nxt;
   logic       w_tx_nxt;
   logic       w_launch;
   logic       w_run;
   logic       w_tick;

   assign w_run = (r_state != IDLE);

   uart_baud_gen #(
      .ClkDiv (ClkDiv)
   ) u_baud (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .i_load  (w_launch),
      .i_run   (w_run),
      .o_tick  (w_tick)
   );

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_stop_cnt_nxt = r_stop_cnt;
      w_launch       = 1'b0;

      case (r_state)
         IDLE: begin
            w_launch = enable && have_next;
         end
         START: begin
            if (w_tick) begin
               w_bit_cnt_nxt = '0;
               w_state_nxt   = DATA;
            end
         end
         DATA: begin
            if (w_tick) begin
               w_shift_nxt = {1'b0, r_shift[7:1]};
               if (r_bit_cnt == 3'd7) begin
                  w_state_nxt    = STOP;
                  w_stop_cnt_nxt = StopCntInit;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               if (r_stop_cnt == 1'b0) begin
                  w_launch    = enable && have_next;
                  w_state_nxt = IDLE;
               end else begin
                  w_stop_cnt_nxt = r_stop_cnt - 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      // A launch from IDLE or from the final stop cycle is the same action.
      if (w_launch) begin
         w_shift_nxt = data;
         w_state_nxt = START;
      end

      // tx is registered from the next state so the line changes exactly at
      // the edge that enters each bit slot.
      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_tx       <= 1'b1;
         r_next     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_stop_cnt <= w_stop_cnt_nxt;
         r_tx       <= w_tx_nxt;
         r_next     <= w_launch;
         r_busy     <= (w_state_nxt != IDLE);
      end
   end

   assign next = r_next;
   assign tx   = r_tx;
   assign busy = r_busy;

endmodule
